cpu_mem_guard: RTL

CPU-side consumer of the memory-map configuration published by the controller (IM bottom/top, DM bottom/top, continue). Sits between the soft CPU's memory request port and the instruction/data memory ports. Latches the region bounds when the CPU is released, range- and alignment-checks every CPU access, routes legal requests to the IM or DM port through a one-entry output register, and halts the CPU on the first violation with a recorded fault address and code.

---
 rtl/cpu_mem_guard_if.sv | 29 ++
 rtl/cpu_mem_guard.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cpu_mem_guard_if.sv
// CPU request / memory forward bus seen by the memory guard.
// master: the CPU side plus the downstream ready signals; slave: the guard itself.
interface cpu_mem_guard_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_fetch;
    logic              req_write;
    logic              im_valid;
    logic              dm_valid;
    logic              im_ready;
    logic              dm_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [1:0]        out_size;
    logic              out_write;

    modport master (
        output req_valid, req_addr, req_size, req_fetch, req_write, im_ready, dm_ready,
        input  req_ready, im_valid, dm_valid, out_addr, out_size, out_write
    );

    modport slave (
        input  req_valid, req_addr, req_size, req_fetch, req_write, im_ready, dm_ready,
        output req_ready, im_valid, dm_valid, out_addr, out_size, out_write
    );
endinterface

// File: rtl/cpu_mem_guard.sv
// Memory guard between the soft CPU and the IM/DM ports: latches region bounds
// on release, range/alignment-checks each request, forwards legal ones through
// a one-entry output register and halts on the first violation.
module cpu_mem_guard #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] IMBottom,
    input  logic [ADDR_W-1:0] IMTop,
    input  logic [ADDR_W-1:0] DMBottom,
    input  logic [ADDR_W-1:0] DMTop,
    input  logic              continue_val,
    cpu_mem_guard_if.slave    bus,
    output logic              running,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [CNT_W-1:0]  fault_count
);
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] im_bot, im_top, dm_bot, dm_top;

    logic              out_vld, out_fetch, out_write_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [1:0]        out_size_q;

    logic [ADDR_W-1:0] size_mask;
    logic [ADDR_W:0]   req_end;
    logic              misaligned, in_range, sel_ready, drain, ready, accept, bad_cfg;
    logic [1:0]        chk_code;

    // Request check against latched bounds; end computed one bit wider so a
    // wrap past the top of the address space can never pass the top-bound compare.
    always_comb begin
        size_mask = '0;
        case (bus.req_size)
            2'd0:    size_mask = '0;
            2'd1:    size_mask = ADDR_W'(1);
            2'd2:    size_mask = ADDR_W'(3);
            default: size_mask = ADDR_W'(7);
        endcase
        misaligned = |(bus.req_addr & size_mask);
        req_end    = {1'b0, bus.req_addr} + {1'b0, size_mask};
        if (bus.req_fetch)
            in_range = (bus.req_addr >= im_bot) && (req_end <= {1'b0, im_top});
        else
            in_range = (bus.req_addr >= dm_bot) && (req_end <= {1'b0, dm_top});
        chk_code = misaligned ? 2'd2 : (in_range ? 2'd0 : 2'd1);
    end

    // Handshake: accept only while running and the output slot is free or leaving.
    always_comb begin
        sel_ready = out_fetch ? bus.im_ready : bus.dm_ready;
        drain     = out_vld & sel_ready;
        ready     = (state == RUN) & continue_val & (~out_vld | sel_ready);
        accept    = bus.req_valid & ready;
        bad_cfg   = (IMBottom > IMTop) || (DMBottom > DMTop) ||
                    ((IMTop >= DMBottom) && (DMTop >= IMBottom));
    end

    assign bus.req_ready = ready;
    assign bus.im_valid  = out_vld & out_fetch;
    assign bus.dm_valid  = out_vld & ~out_fetch;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_size  = out_size_q;
    assign bus.out_write = out_write_q;
    assign running       = (state == RUN);
    assign fault         = (state == FAULT);

    // State machine, bound latching, output register and fault recording.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            im_bot      <= '0;
            im_top      <= '0;
            dm_bot      <= '0;
            dm_top      <= '0;
            out_vld     <= 1'b0;
            out_fetch   <= 1'b0;
            out_addr_q  <= '0;
            out_size_q  <= '0;
            out_write_q <= 1'b0;
            fault_code  <= '0;
            fault_addr  <= '0;
            fault_count <= '0;
        end else begin
            // Drain and refill may coincide; the refill wins so there is no bubble.
            if (drain)
                out_vld <= 1'b0;
            if (accept && chk_code == 2'd0) begin
                out_vld     <= 1'b1;
                out_fetch   <= bus.req_fetch;
                out_addr_q  <= bus.req_addr;
                out_size_q  <= bus.req_size;
                out_write_q <= bus.req_write & ~bus.req_fetch;
            end
            case (state)
                IDLE: begin
                    if (continue_val) begin
                        im_bot <= IMBottom;
                        im_top <= IMTop;
                        dm_bot <= DMBottom;
                        dm_top <= DMTop;
                        if (bad_cfg) begin
                            state      <= FAULT;
                            fault_code <= 2'd3;
                            fault_addr <= '0;
                            if (fault_count != '1)
                                fault_count <= fault_count + CNT_W'(1);
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!continue_val) begin
                        if (!out_vld || drain)
                            state <= IDLE;
                    end else if (accept && chk_code != 2'd0) begin
                        state      <= FAULT;
                        fault_code <= chk_code;
                        fault_addr <= bus.req_addr;
                        if (fault_count != '1)
                            fault_count <= fault_count + CNT_W'(1);
                    end
                end
                FAULT: begin
                    if (!continue_val)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
